keypad_scanner: RTL and testbench

Scans a 4x4 active-low matrix keypad and delivers debounced key codes to the CPU board logic. It is the input-side counterpart of the multiplexed seven-segment display path. The block drives one-cold row strobes in the same style as the display digit selects and samples the column returns. It emits a 4-bit hex key code with a one-cycle valid strobe, suitable for feeding display data or selecting the display mode.

---
 rtl/keypad_pkg.sv | 43 ++++
 rtl/col_sync.sv | 34 +++
 rtl/keypad_scanner.sv | 168 ++++++++++++++++
 tb/tb_keypad_scanner.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and constants for the matrix keypad scanner.
//   state_t      - scanner FSM states
//   ROW0..ROW3   - one-cold, active-low row strobe patterns
//   COL_IDLE     - column return value with no key pressed
//   row_strobe() - row index to strobe pattern
//   lowest_low() - index of the lowest-numbered low column bit
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD,
    RELEASE
  } state_t;

  localparam logic [3:0] ROW0     = 4'b0111;
  localparam logic [3:0] ROW1     = 4'b1011;
  localparam logic [3:0] ROW2     = 4'b1101;
  localparam logic [3:0] ROW3     = 4'b1110;
  localparam logic [3:0] COL_IDLE = 4'b1111;

  function automatic logic [3:0] row_strobe(input logic [1:0] idx);
    logic [3:0] s;
    case (idx)
      2'd0:    s = ROW0;
      2'd1:    s = ROW1;
      2'd2:    s = ROW2;
      default: s = ROW3;
    endcase
    return s;
  endfunction

  // Caller guarantees at least one bit is low; all-high maps to 3.
  function automatic logic [1:0] lowest_low(input logic [3:0] c);
    logic [1:0] i;
    if (!c[0])      i = 2'd0;
    else if (!c[1]) i = 2'd1;
    else if (!c[2]) i = 2'd2;
    else            i = 2'd3;
    return i;
  endfunction

endpackage

// File: rtl/col_sync.sv
// col_sync: two-flop synchronizer for asynchronous level inputs
// (keypad columns, board switches). Resets to all-ones, the idle
// level of active-low inputs.
//   clk   - destination clock
//   reset - asynchronous, active-high
//   din   - asynchronous input bus
//   dout  - synchronized output, two clk cycles behind din
module col_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] sync_p0;
  logic [WIDTH-1:0] sync_p1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0 <= '1;
      sync_p1 <= '1;
    end else begin
      // stage 0: capture, may go metastable
      sync_p0 <= din;
      // stage 1: resolved value
      sync_p1 <= sync_p0;
    end
  end

  assign dout = sync_p1;

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low matrix keypad, debounces press
// and release, and reports the key code with a one-cycle valid strobe.
//   clk       - system clock, rising edge
//   reset     - asynchronous, active-high
//   col       - column returns, active-low, asynchronous to clk
//   row       - one-cold active-low row strobe (registered)
//   key_code  - row_index*4 + col_index of the last accepted key
//   key_valid - one-cycle pulse on each accepted press
//   key_held  - high from acceptance until release is confirmed
// Optional build macro KEYPAD_REPEAT_EN: while a key stays held,
// key_valid pulses again every REPEAT_SCANS samples.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 2500,
  parameter int DEBOUNCE_SCANS = 8,
  parameter int REPEAT_SCANS   = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DIV_W   = $clog2(SCAN_DIV);
  // One counter serves press, release and repeat counting; they are
  // never active in the same state.
  localparam int CNT_MAX = (DEBOUNCE_SCANS > REPEAT_SCANS) ? DEBOUNCE_SCANS : REPEAT_SCANS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_SCANS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam bit               DEB_ONE  = (DEBOUNCE_SCANS == 1);
`ifdef KEYPAD_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_SCANS - 1);
`endif

  logic [3:0]       col_s;
  state_t           state;
  logic [DIV_W-1:0] div;
  logic [1:0]       row_idx;
  logic [1:0]       cand_col;
  logic [CNT_W-1:0] cnt;

  logic             sample;
  logic [1:0]       row_adv;
  logic [1:0]       hit_col;
  logic             cand_low;

  col_sync #(.WIDTH(4)) u_col_sync (
    .clk   (clk),
    .reset (reset),
    .din   (col),
    .dout  (col_s)
  );

  assign sample   = (div == DIV_LAST);
  assign row_adv  = row_idx + 2'd1;
  assign hit_col  = lowest_low(col_s);
  assign cand_low = ~col_s[cand_col];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= SCAN;
      div       <= '0;
      row_idx   <= 2'd0;
      row       <= ROW0;
      cand_col  <= 2'd0;
      cnt       <= '0;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      div       <= sample ? '0 : div + 1'b1;

      if (sample) begin
        unique case (state)
          SCAN: begin
            if (col_s == COL_IDLE) begin
              row_idx <= row_adv;
              row     <= row_strobe(row_adv);
            end else begin
              // Row stays frozen while the candidate is judged.
              cand_col <= hit_col;
              if (DEB_ONE) begin
                key_code  <= {row_idx, hit_col};
                key_valid <= 1'b1;
                key_held  <= 1'b1;
                cnt       <= '0;
                state     <= HELD;
              end else begin
                cnt   <= CNT_ONE;
                state <= DEBOUNCE;
              end
            end
          end

          DEBOUNCE: begin
            if (cand_low) begin
              if (cnt == DEB_LAST) begin
                key_code  <= {row_idx, cand_col};
                key_valid <= 1'b1;
                key_held  <= 1'b1;
                cnt       <= '0;
                state     <= HELD;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end else begin
              cnt     <= '0;
              row_idx <= row_adv;
              row     <= row_strobe(row_adv);
              state   <= SCAN;
            end
          end

          HELD: begin
            // Only the accepted column is watched; no rollover.
            if (!cand_low) begin
              if (DEB_ONE) begin
                key_held <= 1'b0;
                cnt      <= '0;
                row_idx  <= row_adv;
                row      <= row_strobe(row_adv);
                state    <= SCAN;
              end else begin
                cnt   <= CNT_ONE;
                state <= RELEASE;
              end
            end
`ifdef KEYPAD_REPEAT_EN
            else if (cnt == REP_LAST) begin
              cnt       <= '0;
              key_valid <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
`endif
          end

          RELEASE: begin
            if (!cand_low) begin
              if (cnt == DEB_LAST) begin
                key_held <= 1'b0;
                cnt      <= '0;
                row_idx  <= row_adv;
                row      <= row_strobe(row_adv);
                state    <= SCAN;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end else begin
              // Release bounce: back to holding without a new strobe.
              cnt   <= '0;
              state <= HELD;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: drives a physical 4x4 keypad model against
// keypad_scanner and compares every output every cycle with a
// behavioural model, plus literal expectations for the directed cases.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 3;
  localparam int REP      = 5;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] col;
  logic [3:0] row;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [15:0] keys = 16'h0;      // pressed switches, bit = r*4+c
  logic        open_all = 1'b0;   // forces every column open (contact bounce)

  int vectors     = 0;
  int miscompares = 0;
  int valid_seen  = 0;
  bit checking    = 1'b0;

  keypad_scanner #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_SCANS (DEB),
    .REPEAT_SCANS   (REP)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .col       (col),
    .row       (row),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  // Physical keypad: a pressed switch pulls its column low while its row is strobed.
  always_comb begin
    col = 4'hF;
    if (!open_all)
      for (int r = 0; r < 4; r++)
        if (row[3-r] == 1'b0)
          for (int c = 0; c < 4; c++)
            if (keys[r*4+c]) col[c] = 1'b0;
  end

  // ---------------- behavioural model ----------------
  int         m_phase;        // cycle position within the row dwell
  int         m_row;          // row being strobed
  int         m_cand;         // candidate column, -1 when none
  int         m_press_run;    // consecutive low samples of the candidate
  int         m_release_run;  // consecutive high samples after acceptance
  int         m_rep;
  bit         m_accepted;
  logic [3:0] m_hist [0:1];   // column values seen at the last two edges
  logic [3:0] exp_row;
  logic [3:0] exp_code;
  logic       exp_valid;
  logic       exp_held;
  logic [3:0] one_hot_top = 4'b1000;

  function automatic int lowest_low_of(input logic [3:0] c);
    for (int i = 0; i < 4; i++) if (!c[i]) return i;
    return -1;
  endfunction

  task automatic model_accept();
    exp_code      = 4'(m_row * 4 + m_cand);
    exp_valid     = 1'b1;
    m_accepted    = 1'b1;
    m_release_run = 0;
    m_rep         = 0;
  endtask

  task automatic model_next_row();
    m_row = (m_row + 1) % 4;
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase = 0; m_row = 0; m_cand = -1; m_press_run = 0; m_release_run = 0;
      m_rep = 0; m_accepted = 1'b0; m_hist[0] = 4'hF; m_hist[1] = 4'hF;
      exp_code = 4'h0; exp_valid = 1'b0;
    end else begin
      logic [3:0] seen;
      seen      = m_hist[1];
      exp_valid = 1'b0;
      if (m_phase == SCAN_DIV - 1) begin
        if (!m_accepted && m_cand < 0) begin
          if (seen == 4'hF) model_next_row();
          else begin
            m_cand = lowest_low_of(seen);
            m_press_run = 1;
            if (m_press_run >= DEB) model_accept();
          end
        end else if (!m_accepted) begin
          if (!seen[m_cand]) begin
            m_press_run++;
            if (m_press_run >= DEB) model_accept();
          end else begin
            m_cand = -1; m_press_run = 0; model_next_row();
          end
        end else if (m_release_run == 0 && !seen[m_cand]) begin
`ifdef KEYPAD_REPEAT_EN
          m_rep++;
          if (m_rep == REP) begin m_rep = 0; exp_valid = 1'b1; end
`endif
        end else if (seen[m_cand]) begin
          m_release_run++;
          m_rep = 0;
          if (m_release_run >= DEB) begin
            m_accepted = 1'b0; m_cand = -1; m_release_run = 0; m_press_run = 0;
            model_next_row();
          end
        end else begin
          m_release_run = 0; m_rep = 0;
        end
      end
      m_phase   = (m_phase + 1) % SCAN_DIV;
      m_hist[1] = m_hist[0];
      m_hist[0] = col;
    end
    exp_row  = ~(one_hot_top >> m_row);
    exp_held = m_accepted;
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (checking) begin
      vectors++;
      if (row !== exp_row || key_code !== exp_code ||
          key_valid !== exp_valid || key_held !== exp_held) begin
        miscompares++;
        $display("FAIL cycle_compare t=%0t: row=%b code=%h valid=%b held=%b, required row=%b code=%h valid=%b held=%b",
                 $time, row, key_code, key_valid, key_held, exp_row, exp_code, exp_valid, exp_held);
      end
      if (key_valid === 1'b1) valid_seen++;
    end
  end

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic wait_row(input logic [3:0] r);
    int n;
    n = 0;
    while (row === r && n < 40) begin @(negedge clk); n++; end
    while (row !== r && n < 80) begin @(negedge clk); n++; end
    check("wait_row_timeout", int'(row === r), 1);
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (key_valid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    check(name, int'(key_valid === 1'b1), 1);
  endtask

  task automatic wait_unheld(input string name);
    int n;
    n = 0;
    while (key_held !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    check(name, int'(key_held === 1'b0), 1);
  endtask

  int v0;
  int bad;
  int gap;
  int k;
  logic [3:0] want;

  initial begin
    reset = 1'b0;
    #1 reset = 1'b1;
    checking = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_row", int'(row), 4'b0111);
    check("reset_code", int'(key_code), 0);
    check("reset_valid", int'(key_valid), 0);
    check("reset_held", int'(key_held), 0);
    reset = 1'b0;

    // Idle scan: one row per SCAN_DIV cycles, no strobes.
    v0 = valid_seen; bad = 0;
    for (int i = 1; i <= 64; i++) begin
      @(negedge clk);
      want = ~(one_hot_top >> ((i / 4) % 4));
      if (row !== want) bad++;
    end
    check("idle_row_sequence_errors", bad, 0);
    check("idle_no_valid", valid_seen - v0, 0);
    check("idle_code", int'(key_code), 0);

    // Clean press of row 2, column 1.
    wait_row(4'b1101);
    v0 = valid_seen;
    keys = 16'h0200;
    wait_valid("press_valid_timeout");
    check("press_code", int'(key_code), 9);
    @(negedge clk);
    check("press_valid_one_cycle", int'(key_valid), 0);
    check("press_held", int'(key_held), 1);
`ifdef KEYPAD_REPEAT_EN
    gap = 0;
    while (key_valid !== 1'b1 && gap < 60) begin @(negedge clk); gap++; end
    check("repeat_period", gap + 1, REP * SCAN_DIV);
`endif
    repeat (6) @(negedge clk);
    keys = 16'h0;
    bad = 0;
    repeat (8) begin @(negedge clk); if (key_held !== 1'b1) bad++; end
    check("release_held_until_confirmed", bad, 0);
    wait_unheld("release_timeout");
`ifndef KEYPAD_REPEAT_EN
    check("press_single_valid", valid_seen - v0, 1);
`endif

    // Bounce reject: row 1, column 0 seen for a single sample.
    wait_row(4'b1011);
    v0 = valid_seen;
    keys = 16'h0010;
    repeat (4) @(negedge clk);
    keys = 16'h0;
    repeat (4) @(negedge clk);
    check("bounce_row_after_reject", int'(row), 4'b1101);
    check("bounce_no_valid", valid_seen - v0, 0);

    // Release glitch while held: row 0, column 2.
    wait_row(4'b0111);
    v0 = valid_seen;
    keys = 16'h0004;
    wait_valid("glitch_press_timeout");
    check("glitch_code", int'(key_code), 2);
    repeat (3) @(negedge clk);
    open_all = 1'b1;
    repeat (4) @(negedge clk);
    open_all = 1'b0;
    repeat (12) @(negedge clk);
    check("glitch_still_held", int'(key_held), 1);
`ifndef KEYPAD_REPEAT_EN
    check("glitch_no_second_valid", valid_seen - v0, 1);
`endif
    keys = 16'h0;
    wait_unheld("glitch_release_timeout");

    // Two columns low on row 3: lowest index wins.
    wait_row(4'b1110);
    keys = 16'h6000;
    wait_valid("multi_valid_timeout");
    check("multi_code", int'(key_code), 13);
    keys = 16'h0;
    wait_unheld("multi_release_timeout");

    // Reset in the middle of debouncing row 1, column 1.
    wait_row(4'b1011);
    keys = 16'h0020;
    repeat (6) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midreset_row", int'(row), 4'b0111);
    check("midreset_held", int'(key_held), 0);
    check("midreset_valid", int'(key_valid), 0);
    keys = 16'h0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Randomized presses, extra keys and contact bounce.
    for (int it = 0; it < 40; it++) begin
      keys = 16'h0;
      k = $urandom_range(0, 15);
      keys[k] = 1'b1;
      if ($urandom_range(0, 3) == 0) begin
        k = $urandom_range(0, 15);
        keys[k] = 1'b1;
      end
      repeat ($urandom_range(1, 70)) @(negedge clk);
      if ($urandom_range(0, 2) == 0) begin
        open_all = 1'b1;
        repeat ($urandom_range(1, 6)) @(negedge clk);
        open_all = 1'b0;
        repeat ($urandom_range(1, 20)) @(negedge clk);
      end
      keys = 16'h0;
      repeat ($urandom_range(1, 50)) @(negedge clk);
    end
    repeat (40) @(negedge clk);

    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
